det3_seq: RTL and testbench

- Sequencer that computes the determinant of a 3x3 signed 8-bit matrix by cofactor expansion along row 0.
- Time-multiplexes one external combinational 2x2 determinant unit (operand format l1={a,b}, l2={c,d}, result a*d-c*b truncated to signed 8 bits, plus overflow flag).
- Also supports a 2x2 mode with a single pass.
- Sits between the coprocessor instruction decode and the shared 2x2 unit.

---
 rtl/det3_seq.sv | 196 +++++++++++++++++++
 tb/tb_det3_seq.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/det3_seq.sv
// 3x3 determinant sequencer: cofactor expansion along row 0 using one shared
// external combinational 2x2 determinant unit; also runs a single-pass 2x2 mode.
module det3_seq #(
    parameter int unsigned ACC_W = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    input  logic [71:0] mat,
    output logic [15:0] m2_l1,
    output logic [15:0] m2_l2,
    input  logic [7:0]  m2_det,
    input  logic        m2_ovf,
    output logic        busy,
    output logic        done,
    output logic [7:0]  det,
    output logic        ovf
);

    localparam int unsigned EL_W   = 8;
    localparam int unsigned MAT_W  = 9 * EL_W;
    localparam int unsigned OP_W   = 2 * EL_W;
    localparam int unsigned PROD_W = 2 * EL_W;
    localparam int unsigned HI_W   = ACC_W - EL_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_M0,
        S_M1,
        S_M2,
        S_CHK,
        S_DONE
    } state_e;

    state_e                     state_q, state_d;
    logic [MAT_W-1:0]           mat_q, mat_d;
    logic                       mode_q, mode_d;
    logic [ACC_W-1:0]           acc_q, acc_d;
    logic                       sticky_q, sticky_d;
    logic [EL_W-1:0]            det_q, det_d;
    logic                       ovf_q, ovf_d;
    logic [OP_W-1:0]            l1_q, l1_d;
    logic [OP_W-1:0]            l2_q, l2_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;

    logic [EL_W-1:0]            mult;
    logic signed [PROD_W-1:0]   prod;
    logic [ACC_W-1:0]           prod_ext;
    logic [ACC_W-1:0]           minor_ext;
    logic [HI_W-1:0]            acc_hi;
    logic                       acc_in_range;

    // Element (r,c) of a packed row-major matrix.
    function automatic logic [EL_W-1:0] el(input logic [MAT_W-1:0] m,
                                           input int unsigned r,
                                           input int unsigned c);
        return m[(3 * r + c) * EL_W +: EL_W];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mat_q    <= '0;
            mode_q   <= 1'b0;
            acc_q    <= '0;
            sticky_q <= 1'b0;
            det_q    <= '0;
            ovf_q    <= 1'b0;
            l1_q     <= '0;
            l2_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            mat_q    <= mat_d;
            mode_q   <= mode_d;
            acc_q    <= acc_d;
            sticky_q <= sticky_d;
            det_q    <= det_d;
            ovf_q    <= ovf_d;
            l1_q     <= l1_d;
            l2_q     <= l2_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mat_d    = mat_q;
        mode_d   = mode_q;
        acc_d    = acc_q;
        sticky_d = sticky_q;
        det_d    = det_q;
        ovf_d    = ovf_q;
        l1_d     = '0;
        l2_d     = '0;

        // Row-0 coefficient paired with the minor currently on the 2x2 unit.
        case (state_q)
            S_M1:    mult = el(mat_q, 0, 1);
            S_M2:    mult = el(mat_q, 0, 2);
            default: mult = el(mat_q, 0, 0);
        endcase
        prod         = $signed(mult) * $signed(m2_det);
        prod_ext     = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
        minor_ext    = {{(ACC_W - EL_W){m2_det[EL_W-1]}}, m2_det};
        acc_hi       = acc_q[ACC_W-1:EL_W-1];
        acc_in_range = (&acc_hi) | ~(|acc_hi);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mat_d   = mat;
                    mode_d  = mode;
                    state_d = S_M0;
                end
            end
            S_M0: begin
                sticky_d = m2_ovf;
                if (mode_q) begin
                    acc_d   = minor_ext;
                    state_d = S_CHK;
                end else begin
                    acc_d   = prod_ext;
                    state_d = S_M1;
                end
            end
            S_M1: begin
                acc_d    = acc_q - prod_ext;
                sticky_d = sticky_q | m2_ovf;
                state_d  = S_M2;
            end
            S_M2: begin
                acc_d    = acc_q + prod_ext;
                sticky_d = sticky_q | m2_ovf;
                state_d  = S_CHK;
            end
            S_CHK: begin
                det_d   = acc_q[EL_W-1:0];
                ovf_d   = sticky_q | ~acc_in_range;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Operands are registered one cycle ahead, so they follow the next state.
        case (state_d)
            S_M0: begin
                if (mode_d) begin
                    l1_d = {el(mat_d, 0, 0), el(mat_d, 0, 1)};
                    l2_d = {el(mat_d, 1, 0), el(mat_d, 1, 1)};
                end else begin
                    l1_d = {el(mat_d, 1, 1), el(mat_d, 1, 2)};
                    l2_d = {el(mat_d, 2, 1), el(mat_d, 2, 2)};
                end
            end
            S_M1: begin
                l1_d = {el(mat_d, 1, 0), el(mat_d, 1, 2)};
                l2_d = {el(mat_d, 2, 0), el(mat_d, 2, 2)};
            end
            S_M2: begin
                l1_d = {el(mat_d, 1, 0), el(mat_d, 1, 1)};
                l2_d = {el(mat_d, 2, 0), el(mat_d, 2, 1)};
            end
            default: begin
                l1_d = '0;
                l2_d = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    assign m2_l1 = l1_q;
    assign m2_l2 = l2_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign det   = det_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_det3_seq.sv
// Bench for det3_seq: behavioural determinant/timing model with a per-cycle
// compare process, a model of the shared 2x2 unit, and directed literal checks.
module tb_det3_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [71:0] mat;
    logic [15:0] m2_l1;
    logic [15:0] m2_l2;
    logic [7:0]  m2_det;
    logic        m2_ovf;
    logic        busy;
    logic        done;
    logic [7:0]  det;
    logic        ovf;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    det3_seq #(.ACC_W(18)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mode   (mode),
        .mat    (mat),
        .m2_l1  (m2_l1),
        .m2_l2  (m2_l2),
        .m2_det (m2_det),
        .m2_ovf (m2_ovf),
        .busy   (busy),
        .done   (done),
        .det    (det),
        .ovf    (ovf)
    );

    function automatic int sx(input logic [7:0] v);
        return int'($signed(v));
    endfunction

    function automatic int minor(input int a, input int b, input int c, input int d);
        return a * d - c * b;
    endfunction

    function automatic int trunc8(input int x);
        logic [7:0] b;
        b = x[7:0];
        return int'($signed(b));
    endfunction

    function automatic logic [71:0] mk(input int a00, input int a01, input int a02,
                                       input int a10, input int a11, input int a12,
                                       input int a20, input int a21, input int a22);
        return {8'(a22), 8'(a21), 8'(a20), 8'(a12), 8'(a11), 8'(a10),
                8'(a02), 8'(a01), 8'(a00)};
    endfunction

    function automatic int elm(input logic [71:0] m, input int r, input int c);
        return sx(m[(3 * r + c) * 8 +: 8]);
    endfunction

    // Shared 2x2 determinant unit.
    int r2;
    always_comb r2 = minor(sx(m2_l1[15:8]), sx(m2_l1[7:0]), sx(m2_l2[15:8]), sx(m2_l2[7:0]));
    assign m2_det = r2[7:0];
    assign m2_ovf = (r2 > 127) || (r2 < -128);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Determinant from the matrix, using 8-bit-truncated minors as the hardware does.
    task automatic model_result(input logic [71:0] m, input logic md,
                                output logic [7:0] d, output logic o);
        int x0, x1, x2, acc;
        logic any;
        if (md) begin
            x0  = minor(elm(m,0,0), elm(m,0,1), elm(m,1,0), elm(m,1,1));
            acc = trunc8(x0);
            any = (x0 > 127) || (x0 < -128);
        end else begin
            x0  = minor(elm(m,1,1), elm(m,1,2), elm(m,2,1), elm(m,2,2));
            x1  = minor(elm(m,1,0), elm(m,1,2), elm(m,2,0), elm(m,2,2));
            x2  = minor(elm(m,1,0), elm(m,1,1), elm(m,2,0), elm(m,2,1));
            acc = elm(m,0,0) * trunc8(x0) - elm(m,0,1) * trunc8(x1) + elm(m,0,2) * trunc8(x2);
            any = (x0 > 127) || (x0 < -128) || (x1 > 127) || (x1 < -128) ||
                  (x2 > 127) || (x2 < -128);
        end
        d = acc[7:0];
        o = any || (acc > 127) || (acc < -128);
    endtask

    // Timing model: cnt counts cycles since acceptance (0 = idle).
    int          cnt = 0;
    int          lat = 5;
    logic [71:0] mmat = '0;
    logic        mmode = 1'b0;
    logic [7:0]  e_det = '0, r_det = '0;
    logic        e_ovf = 1'b0, r_ovf = 1'b0;
    bit          chk_en = 1'b0;

    function automatic logic [7:0] e8(input int r, input int c);
        return mmat[(3 * r + c) * 8 +: 8];
    endfunction

    function automatic logic [31:0] exp_ops();
        if (cnt == 1 && mmode)  return {e8(0,0), e8(0,1), e8(1,0), e8(1,1)};
        if (cnt == 1)           return {e8(1,1), e8(1,2), e8(2,1), e8(2,2)};
        if (cnt == 2 && !mmode) return {e8(1,0), e8(1,2), e8(2,0), e8(2,2)};
        if (cnt == 3 && !mmode) return {e8(1,0), e8(1,1), e8(2,0), e8(2,1)};
        return 32'h0;
    endfunction

    always @(posedge clk) begin
        chk_en = 1'b1;
        if (rst) begin
            cnt   = 0;
            e_det = '0;
            e_ovf = 1'b0;
        end else if (cnt == 0) begin
            if (start) begin
                mmat  = mat;
                mmode = mode;
                lat   = mode ? 3 : 5;
                model_result(mat, mode, r_det, r_ovf);
                cnt   = 1;
            end
        end else begin
            cnt++;
            if (cnt == lat) begin
                e_det = r_det;
                e_ovf = r_ovf;
            end
            if (cnt > lat) cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(cnt != 0));
            chk("done", 32'(done), 32'(cnt != 0 && cnt == lat));
            chk("det",  32'(det),  32'(e_det));
            chk("ovf",  32'(ovf),  32'(e_ovf));
            chk("ops",  {m2_l1, m2_l2}, exp_ops());
        end
    end

    // One operation with literal latency/result expectations; mat is scrambled after start.
    task automatic run_op(input logic [71:0] m, input logic md, input logic [7:0] xd,
                          input logic xo, input int xl, input string nm);
        int cyc, nb;
        @(negedge clk);
        mat = m; mode = md; start = 1'b1;
        @(negedge clk);
        start = 1'b0; mat = ~m; mode = ~md;
        cyc = 1;
        nb  = int'(busy);
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
            nb += int'(busy);
        end
        chk({nm, "_lat"},  32'(cyc), 32'(xl));
        chk({nm, "_busy"}, 32'(nb),  32'(xl));
        chk({nm, "_det"},  32'(det), 32'(xd));
        chk({nm, "_ovf"},  32'(ovf), 32'(xo));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        logic [71:0] m41;
        int ndone;
        m41 = mk(2,1,3, 0,4,5, 1,0,6);
        rst = 1'b1; start = 1'b0; mode = 1'b0; mat = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_det",  32'(det),  32'd0);
        chk("rst_ops",  {m2_l1, m2_l2}, 32'd0);
        rst = 1'b0;

        run_op(mk(1,0,0, 0,1,0, 0,0,1), 1'b0, 8'd1, 1'b0, 5, "ident");

        // Operand sequence for a known 3x3.
        @(negedge clk);
        mat = m41; mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("m0_l1", 32'(m2_l1), 32'h0405);
        chk("m0_l2", 32'(m2_l2), 32'h0006);
        @(negedge clk);
        chk("m1_l1", 32'(m2_l1), 32'h0005);
        chk("m1_l2", 32'(m2_l2), 32'h0106);
        @(negedge clk);
        chk("m2_l1", 32'(m2_l1), 32'h0004);
        chk("m2_l2", 32'(m2_l2), 32'h0100);
        repeat (2) @(negedge clk);
        chk("m41_done", 32'(done), 32'd1);
        chk("m41_det",  32'(det),  32'h29);
        chk("m41_ovf",  32'(ovf),  32'd0);

        run_op(mk(10,0,0, 0,10,0, 0,0,10), 1'b0, 8'hE8, 1'b1, 5, "diag10");
        run_op(mk(0,0,0, 0,20,0, 0,0,20),  1'b0, 8'h00, 1'b1, 5, "sticky");
        run_op(mk(3,2,99, 1,4,-7, 55,-100,127), 1'b1, 8'd10, 1'b0, 3, "mode2");
        run_op(mk(-128,-128,-128, -128,-128,-128, -128,-128,-128), 1'b0, 8'h00, 1'b0, 5, "allneg");
        run_op(mk(-128,0,0, 0,1,0, 0,0,1), 1'b0, 8'h80, 1'b0, 5, "lowedge");
        run_op(mk(2,0,0, 0,8,0, 0,0,8),    1'b0, 8'h80, 1'b1, 5, "highedge");
        run_op(mk(3,2,0, 1,4,0, 0,0,0),    1'b1, 8'd10, 1'b0, 3, "mode2b");

        // Start during M1 is ignored; reset in M2 aborts with no done pulse.
        @(negedge clk);
        mat = m41; mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_det",  32'(det),  32'd0);
        chk("abort_ovf",  32'(ovf),  32'd0);
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            ndone += int'(done);
        end
        chk("abort_nodone", 32'(ndone), 32'd0);
        run_op(m41, 1'b0, 8'h29, 1'b0, 5, "after_rst");

        // Start held high: operations every 6 cycles.
        @(negedge clk);
        mat = mk(2,0,0, 0,3,0, 0,0,4); mode = 1'b0; start = 1'b1;
        ndone = 0;
        repeat (13) begin
            @(negedge clk);
            ndone += int'(done);
        end
        start = 1'b0;
        repeat (8) begin
            @(negedge clk);
            ndone += int'(done);
        end
        chk("b2b_count", 32'(ndone), 32'd3);
        chk("b2b_det",   32'(det),   32'd24);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
